memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline MEM stage of the five-stage RV32I core, sitting between the EX/MEM register and the write-back stage. It issues loads and stores to the data memory over a req/ack handshake that tolerates variable latency. It aligns and sign-extends load data and stalls the pipeline while an access is outstanding. It also owns the MEM/WB pipeline register that feeds the write-back mux.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  core clock; all state updates on the rising edge
- srst  in  1  synchronous active-high reset
- valid_m  in  1  MEM-stage slot holds a real instruction
- reg_write_m  in  1  instruction writes rd
- result_src_m  in  2  write-back select: 0 ALU, 1 load data, 2 PC+4
- mem_write_m / mem_read_m  in  1 each  store / load
- funct3_m  in  3  access size and signedness
- rd_m  in  5  destination register
- alu_result_m  in  32  effective address or ALU result
- write_data_m  in  32  store data (rs2)
- pc_plus4_m  in  32  PC+4
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address: {alu_result_m[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  read word; valid when dmem_ack is high on a load
- stall_m  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misaligned_m  out  1  one-cycle misaligned-access flag
- reg_write_w, result_src_w[1:0], rd_w[4:0], read_data_w[31:0], alu_result_w[31:0], pc_plus4_w[31:0]  out  MEM/WB register contents

## Operation
- mem_op = valid_m & (mem_read_m | mem_write_m) & ~misaligned.
- Misaligned access:
  - Condition: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Response: misaligned_m=1, no request issued, and WB receives a bubble (reg_write_w=0).
- Supported funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Store byte enables: 0001/0011/1111 shifted left by addr[1:0].
- Store data: wdata replicates the byte or half across all lanes.
- Load data: select the addressed byte or half, then zero- or sign-extend to 32 bits.
- FSM with two states:
  - IDLE: dmem_req = mem_op, driven combinationally from the stage inputs.
    - mem_op & dmem_ack: complete in the same cycle (zero-wait); stay in IDLE.
    - mem_op & ~dmem_ack: go to WAIT.
  - WAIT: dmem_req held at 1. The request fields stay stable because the upstream inputs are frozen.
    - dmem_ack: complete and return to IDLE.
- stall_m = mem_op & ~dmem_ack, in both states.
- MEM/WB register, each cycle:
  - Instruction completing (non-memory and valid, or memory with ack): capture all fields. read_data_w takes the aligned load data; on stores it is don't-care.
  - Stall cycle or valid_m=0: reg_write_w=0. The other fields are don't-care but deterministic (captured anyway).
- Stores complete on ack with reg_write_w=0 regardless of reg_write_m.
- A dmem_ack while no request is outstanding is ignored.

## Timing
- Reset values:
  - State: IDLE.
  - All MEM/WB outputs: 0.
  - Combinational outputs: dmem_req, stall_m and misaligned_m evaluate to 0 under reset.
- Latency:
  - Non-memory instruction: one cycle to the WB outputs.
  - Memory access with ack arriving N cycles after first request: N+1 cycles to WB, with N stall cycles.
- Handshake: dmem_req stays high until dmem_ack is sampled. Fields must not change while req is high.
- Reset during WAIT: state → IDLE and req drops in that cycle. An ack arriving later is ignored.
- Ack and srst in the same cycle: reset wins; nothing is captured.

## Structure
- The shared package riscv_pkg holds:
  - result_src enum: RES_ALU=2'd0, RES_MEM=2'd1, RES_PC4=2'd2.
  - Load/store funct3 constants.
  - mem_state_e {IDLE, WAIT}.
- Sub-module load_align: combinational (rdata, addr[1:0], funct3) → extended 32-bit value.
- Store lane steering stays inline.

## Test plan
- ADD with alu_result_m=0x1234, rd=5 → next cycle reg_write_w=1, rd_w=5, alu_result_w=0x1234, stall_m never set.
- LB at 0x103, memory word 0x80FF_0000, ack after 3 cycles → dmem_addr=0x100, stall_m high for 3 cycles, read_data_w=0xFFFF_FF80. With LBU instead → 0x0000_0080.
- SH at 0x202, data 0x0000_ABCD, zero-wait ack → dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, no stall, reg_write_w=0.
- LW at 0x301 → misaligned_m=1 for one cycle, dmem_req=0, reg_write_w=0.
- LW waiting, srst asserted on the 2nd wait cycle, ack one cycle later → IDLE, dmem_req=0, all WB outputs 0, late ack has no effect.
- Spurious dmem_ack with valid_m=0 → no capture, reg_write_w=0, state stays IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions used by the MEM stage.
//   result_src_e : write-back mux select encoding
//   F3_*         : load/store funct3 codes
//   mem_state_e  : data-memory handshake FSM states
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2
   } result_src_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word and
// zero- or sign-extends it to 32 bits.
//   rdata   in  32  word returned by data memory
//   addr_lo in  2   byte offset of the access
//   funct3  in  3   load size / signedness
//   data_o  out 32  extended load value
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      case (funct3)
         F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   data_o = {24'h0, shifted[7:0]};
         F3_HU:   data_o = {16'h0, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: issues loads/stores over a variable-latency req/ack
// handshake, stalls upstream while an access is outstanding, aligns load data
// and holds the MEM/WB pipeline register.
//   *_m inputs      : EX/MEM register contents
//   dmem_*          : data-memory request/response
//   stall_m         : freeze upstream stages
//   misaligned_m    : one-cycle misaligned-access flag
//   *_w outputs     : MEM/WB register contents
//
// state | meaning
// IDLE  | no access outstanding; req follows the stage inputs directly
// WAIT  | request issued, waiting for dmem_ack
module memory_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        srst,
   input  logic        valid_m,
   input  logic        reg_write_m,
   input  logic [1:0]  result_src_m,
   input  logic        mem_write_m,
   input  logic        mem_read_m,
   input  logic [2:0]  funct3_m,
   input  logic [4:0]  rd_m,
   input  logic [31:0] alu_result_m,
   input  logic [31:0] write_data_m,
   input  logic [31:0] pc_plus4_m,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_m,
   output logic        misaligned_m,
   output logic        reg_write_w,
   output logic [1:0]  result_src_w,
   output logic [4:0]  rd_w,
   output logic [31:0] read_data_w,
   output logic [31:0] alu_result_w,
   output logic [31:0] pc_plus4_w
);

   mem_state_e  state_q, state_d;
   logic        reg_write_w_q, reg_write_w_d;
   logic [1:0]  result_src_w_q;
   logic [4:0]  rd_w_q;
   logic [31:0] read_data_w_q, read_data_w_d;
   logic [31:0] alu_result_w_q;
   logic [31:0] pc_plus4_w_q;

   logic        mem_acc, misaligned, mem_op, complete;
   logic [3:0]  be_base;
   logic [31:0] load_data;

   assign mem_acc    = valid_m & (mem_read_m | mem_write_m);
   assign misaligned = mem_acc &
                       (((funct3_m[1:0] == 2'b01) & alu_result_m[0]) |
                        ((funct3_m[1:0] == 2'b10) & (|alu_result_m[1:0])));
   assign mem_op     = mem_acc & ~misaligned;

   // Non-memory instructions complete immediately; memory ones only on ack.
   assign complete   = valid_m & ~misaligned & (~mem_acc | dmem_ack);

   always_comb begin
      state_d  = state_q;
      dmem_req = 1'b0;
      case (state_q)
         IDLE: begin
            dmem_req = mem_op;
            if (mem_op && !dmem_ack) state_d = WAIT;
         end
         WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (srst) dmem_req = 1'b0;
   end

   assign stall_m      = mem_op & ~dmem_ack & ~srst;
   assign misaligned_m = misaligned & ~srst;

   // Store lane steering.
   always_comb begin
      case (funct3_m[1:0])
         2'b00:   be_base = 4'b0001;
         2'b01:   be_base = 4'b0011;
         default: be_base = 4'b1111;
      endcase
      case (funct3_m[1:0])
         2'b00:   dmem_wdata = {4{write_data_m[7:0]}};
         2'b01:   dmem_wdata = {2{write_data_m[15:0]}};
         default: dmem_wdata = write_data_m;
      endcase
   end

   assign dmem_be   = be_base << alu_result_m[1:0];
   assign dmem_we   = mem_write_m;
   assign dmem_addr = {alu_result_m[31:2], 2'b00};

   load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (alu_result_m[1:0]),
      .funct3  (funct3_m),
      .data_o  (load_data)
   );

   // Stores never write rd, whatever reg_write_m says.
   assign reg_write_w_d = complete & reg_write_m & ~mem_write_m;
   assign read_data_w_d = load_data;

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q        <= IDLE;
         reg_write_w_q  <= 1'b0;
         result_src_w_q <= 2'b00;
         rd_w_q         <= 5'd0;
         read_data_w_q  <= 32'h0;
         alu_result_w_q <= 32'h0;
         pc_plus4_w_q   <= 32'h0;
      end else begin
         state_q        <= state_d;
         reg_write_w_q  <= reg_write_w_d;
         result_src_w_q <= result_src_m;
         rd_w_q         <= rd_m;
         read_data_w_q  <= read_data_w_d;
         alu_result_w_q <= alu_result_m;
         pc_plus4_w_q   <= pc_plus4_m;
      end
   end

   assign reg_write_w  = reg_write_w_q;
   assign result_src_w = result_src_w_q;
   assign rd_w         = rd_w_q;
   assign read_data_w  = read_data_w_q;
   assign alu_result_w = alu_result_w_q;
   assign pc_plus4_w   = pc_plus4_w_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        srst;
   logic        valid_m, reg_write_m, mem_write_m, mem_read_m;
   logic [1:0]  result_src_m;
   logic [2:0]  funct3_m;
   logic [4:0]  rd_m;
   logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
   logic        dmem_req, dmem_we, dmem_ack, stall_m, misaligned_m;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        reg_write_w;
   logic [1:0]  result_src_w;
   logic [4:0]  rd_w;
   logic [31:0] read_data_w, alu_result_w, pc_plus4_w;

   always #5 clk = ~clk;

   memory_stage dut (
      .clk(clk), .srst(srst), .valid_m(valid_m), .reg_write_m(reg_write_m),
      .result_src_m(result_src_m), .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
      .funct3_m(funct3_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
      .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall_m(stall_m), .misaligned_m(misaligned_m),
      .reg_write_w(reg_write_w), .result_src_w(result_src_w), .rd_w(rd_w),
      .read_data_w(read_data_w), .alu_result_w(alu_result_w), .pc_plus4_w(pc_plus4_w)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [1:0]  rs;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] rdata;
   } exp_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] ref_mb [1024];  // reference model memory
   logic [7:0] mem_mb [1024];  // memory seen by the DUT

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int size_of(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
      int n = size_of(f3);
      logic [31:0] v = 0;
      for (int i = 0; i < n; i++) v = v + (32'(ref_mb[a + i]) << (8 * i));
      if (f3[2] == 1'b0 && n == 1 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
      if (f3[2] == 1'b0 && n == 2 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
   endfunction

   // Monitor: every WB write is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (reg_write_w === 1'b1) begin
         if (sb.size() == 0) begin
            check("wb_unexpected_write", 32'(rd_w), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wb_rd", 32'(rd_w), 32'(e.rd));
            check("wb_result_src", 32'(result_src_w), 32'(e.rs));
            check("wb_alu_result", alu_result_w, e.alu);
            check("wb_pc_plus4", pc_plus4_w, e.pc4);
            if (e.rs == 2'd1) check("wb_read_data", read_data_w, e.rdata);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic rd_en, input logic wr_en, input logic rw,
                        input logic [1:0] rs, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                        input int lat);
      int   n   = size_of(f3);
      int   off = int'(alu[1:0]);
      logic acc = rd_en | wr_en;
      logic mis = acc && ((n == 2 && alu[0]) || (n == 4 && alu[1:0] != 0));
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic exp_rw;
      exp_t e;
      valid_m = 1'b1; reg_write_m = rw; result_src_m = rs; mem_read_m = rd_en;
      mem_write_m = wr_en; funct3_m = f3; rd_m = rd; alu_result_m = alu;
      write_data_m = wd; pc_plus4_m = pc4;
      exp_rw = rw && !wr_en && !mis;
      if (exp_rw) begin
         e.rd = rd; e.rs = rs; e.alu = alu; e.pc4 = pc4;
         e.rdata = rd_en ? ref_load(int'(alu[9:0]), f3) : 32'h0;
         sb.push_back(e);
      end
      if (!acc || mis) begin
         dmem_ack = 1'b0;
         @(negedge clk);
         check("req_idle", 32'(dmem_req), 32'h0);
         check("stall_idle", 32'(stall_m), 32'h0);
         check("misaligned", 32'(misaligned_m), 32'(mis));
         @(posedge clk); #1;
      end else begin
         exp_be = 4'((32'(1) << n) - 1) << off;
         for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
         for (int k = 0; k <= lat; k++) begin
            dmem_ack = (k == lat);
            @(negedge clk);
            check("req_hold", 32'(dmem_req), 32'h1);
            check("stall", 32'(stall_m), 32'(k != lat));
            check("misaligned_ok", 32'(misaligned_m), 32'h0);
            check("addr", dmem_addr, {alu[31:2], 2'b00});
            check("we", 32'(dmem_we), 32'(wr_en));
            if (wr_en) begin
               check("be", 32'(dmem_be), 32'(exp_be));
               check("wdata", dmem_wdata, exp_wd);
            end
            dmem_rdata = {mem_mb[(dmem_addr & 32'h3FC) + 3], mem_mb[(dmem_addr & 32'h3FC) + 2],
                          mem_mb[(dmem_addr & 32'h3FC) + 1], mem_mb[dmem_addr & 32'h3FC]};
            if (wr_en && dmem_ack)
               for (int i = 0; i < 4; i++)
                  if (dmem_be[i]) mem_mb[(dmem_addr & 32'h3FC) + i] = dmem_wdata[8*i +: 8];
            @(posedge clk); #1;
         end
         if (wr_en) for (int i = 0; i < n; i++) ref_mb[int'(alu[9:0]) + i] = wd[8*i +: 8];
      end
      check("wb_rw_latency", 32'(reg_write_w), 32'(exp_rw));
      valid_m = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic bubble(input logic ack_v);
      valid_m = 1'b0; dmem_ack = ack_v; dmem_rdata = $urandom;
      @(negedge clk);
      check("bubble_req", 32'(dmem_req), 32'h0);
      check("bubble_stall", 32'(stall_m), 32'h0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("bubble_rw", 32'(reg_write_w), 32'h0);
   endtask

   initial begin
      int kind, lat;
      logic [2:0] f3;
      logic [31:0] a;
      for (int i = 0; i < 1024; i++) begin
         ref_mb[i] = 8'($urandom);
         mem_mb[i] = ref_mb[i];
      end
      srst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      valid_m = 1'b1; reg_write_m = 1'b1; result_src_m = 2'd1; mem_read_m = 1'b1;
      mem_write_m = 1'b0; funct3_m = 3'b010; rd_m = 5'd3; alu_result_m = 32'h301;
      write_data_m = 32'h0; pc_plus4_m = 32'h4;

      // Combinational outputs under reset, misaligned then aligned access.
      @(negedge clk);
      check("rst_misaligned", 32'(misaligned_m), 32'h0);
      check("rst_req_a", 32'(dmem_req), 32'h0);
      @(posedge clk); #1;
      alu_result_m = 32'h300;
      @(negedge clk);
      check("rst_req_b", 32'(dmem_req), 32'h0);
      check("rst_stall", 32'(stall_m), 32'h0);
      check("rst_wb", {reg_write_w, result_src_w, rd_w}, 32'h0);
      check("rst_wb_data", read_data_w | alu_result_w | pc_plus4_w, 32'h0);
      @(posedge clk); #1;
      srst = 1'b0; valid_m = 1'b0;

      // Directed cases.
      issue(0, 0, 1, 2'd0, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h44, 0);
      {mem_mb[259], mem_mb[258], mem_mb[257], mem_mb[256]} = 32'h80FF_0000;
      {ref_mb[259], ref_mb[258], ref_mb[257], ref_mb[256]} = 32'h80FF_0000;
      issue(1, 0, 1, 2'd1, 3'b000, 5'd6, 32'h103, 32'h0, 32'h48, 3);
      check("lb_expect_const", ref_load(32'h103, 3'b000), 32'hFFFF_FF80);
      issue(1, 0, 1, 2'd1, 3'b100, 5'd7, 32'h103, 32'h0, 32'h4C, 3);
      issue(0, 1, 0, 2'd0, 3'b001, 5'd0, 32'h202, 32'h0000_ABCD, 32'h50, 0);
      issue(1, 0, 1, 2'd1, 3'b010, 5'd8, 32'h301, 32'h0, 32'h54, 0);
      bubble(1'b1);
      issue(0, 0, 1, 2'd2, 3'b000, 5'd9, 32'hDEAD_BEEF, 32'h0, 32'h58, 0);

      // Reset while waiting: LW issued, srst on the second wait cycle, late ack.
      valid_m = 1'b1; reg_write_m = 1'b1; result_src_m = 2'd1; mem_read_m = 1'b1;
      mem_write_m = 1'b0; funct3_m = 3'b010; rd_m = 5'd11; alu_result_m = 32'h40;
      dmem_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("wait_req", 32'(dmem_req), 32'h1);
         check("wait_stall", 32'(stall_m), 32'h1);
         @(posedge clk); #1;
      end
      srst = 1'b1;
      @(negedge clk);
      check("srst_req_drop", 32'(dmem_req), 32'h0);
      check("srst_stall", 32'(stall_m), 32'h0);
      @(posedge clk); #1;
      srst = 1'b0; valid_m = 1'b0; dmem_ack = 1'b1;
      @(negedge clk);
      check("late_ack_req", 32'(dmem_req), 32'h0);
      check("post_rst_wb", {reg_write_w, result_src_w, rd_w}, 32'h0);
      check("post_rst_wb_data", read_data_w | alu_result_w | pc_plus4_w, 32'h0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("late_ack_rw", 32'(reg_write_w), 32'h0);
      issue(0, 0, 1, 2'd0, 3'b000, 5'd12, 32'h77, 32'h0, 32'h60, 0);

      // Randomized traffic.
      for (int t = 0; t < 200; t++) begin
         kind = $urandom_range(0, 2);
         lat  = $urandom_range(0, 3);
         a    = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) a = a & 32'h3FC;
         if (kind == 0) begin
            issue(0, 0, 1'($urandom), ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0, 3'($urandom),
                  5'($urandom), $urandom, $urandom, $urandom, 0);
         end else if (kind == 1) begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
            if (f3[1:0] == 2'b00 || $urandom_range(0, 2) != 0) a = a & 32'h3FF;
            issue(1, 0, 1'($urandom_range(0, 7) != 0), 2'd1, f3, 5'($urandom), a,
                  $urandom, $urandom, lat);
         end else begin
            f3 = 3'($urandom_range(0, 2));
            issue(0, 1, 1'($urandom), 2'd0, f3, 5'($urandom), a, $urandom, $urandom, lat);
         end
         if ($urandom_range(0, 4) == 0) bubble(1'($urandom));
      end

      @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
